// File: rtl/fpu_host_ctrl.sv
// fpu_host_ctrl: CPU-side bus master that runs one FPU operation over the 8-bit register window.
// Define FPU_HOST_TIMEOUT_EN to add a watchdog on the wait for fpu_cmd_end.
module fpu_host_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic [3:0]  req_op_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_error_o,
    output logic [3:0]  fpu_addr_o,
    output logic        fpu_cs_o,
    output logic        fpu_rd_o,
    output logic        fpu_wr_o,
    output logic [7:0]  fpu_data_out_o,
    input  logic [7:0]  fpu_data_in_i,
    input  logic        fpu_cmd_end_i,
    output logic        fpu_end_ack_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ASSERT,
        ST_WR_RECOVER,
        ST_WAIT_END,
        ST_RD_ASSERT,
        ST_RD_RECOVER,
        ST_ACK,
        ST_RSP
    } state_t;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  idx_d;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  op_q;
    logic        cs_q;
    logic        rd_q;
    logic        wr_q;
    logic        ack_q;
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [3:0]  addr_q;
    logic [7:0]  data_q;
    logic [31:0] result_q;
    logic [7:0]  wr_byte_d;

`ifdef FPU_HOST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    assign idx_d = idx_q + 4'd1;

    // Byte for the next write slot; slot 0 is loaded straight from the request at acceptance.
    always_comb begin
        wr_byte_d = 8'h00;
        case (idx_d)
            4'd0:    wr_byte_d = a_q[7:0];
            4'd1:    wr_byte_d = a_q[15:8];
            4'd2:    wr_byte_d = a_q[23:16];
            4'd3:    wr_byte_d = a_q[31:24];
            4'd4:    wr_byte_d = b_q[7:0];
            4'd5:    wr_byte_d = b_q[15:8];
            4'd6:    wr_byte_d = b_q[23:16];
            4'd7:    wr_byte_d = b_q[31:24];
            4'd8:    wr_byte_d = {4'h0, op_q};
            default: wr_byte_d = 8'h00;
        endcase
    end

    assign req_ready_o    = (state_q == ST_IDLE) && !fpu_cmd_end_i;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_result_o   = result_q;
    assign rsp_error_o    = rsp_error_q;
    assign fpu_addr_o     = addr_q;
    assign fpu_cs_o       = cs_q;
    assign fpu_rd_o       = rd_q;
    assign fpu_wr_o       = wr_q;
    assign fpu_data_out_o = data_q;
    assign fpu_end_ack_o  = ack_q;

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            op_q        <= 4'h0;
            cs_q        <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            ack_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            addr_q      <= 4'd0;
            data_q      <= 8'h00;
            result_q    <= 32'h0;
`ifdef FPU_HOST_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        a_q      <= req_a_i;
                        b_q      <= req_b_i;
                        op_q     <= req_op_i;
                        idx_q    <= 4'd0;
                        result_q <= 32'h0;
                        if (req_op_i > 4'd3) begin
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                        end else begin
                            state_q     <= ST_WR_ASSERT;
                            rsp_error_q <= 1'b0;
                            cs_q        <= 1'b0;
                            wr_q        <= 1'b0;
                            addr_q      <= 4'd0;
                            data_q      <= req_a_i[7:0];
                        end
                    end
                end
                ST_WR_ASSERT: begin
                    state_q <= ST_WR_RECOVER;
                    cs_q    <= 1'b1;
                    wr_q    <= 1'b1;
                end
                ST_WR_RECOVER: begin
                    if (idx_q == 4'd8) begin
                        state_q <= ST_WAIT_END;
`ifdef FPU_HOST_TIMEOUT_EN
                        tmo_q   <= TMO_LOAD;
`endif
                    end else begin
                        state_q <= ST_WR_ASSERT;
                        idx_q   <= idx_d;
                        addr_q  <= idx_d;
                        data_q  <= wr_byte_d;
                        cs_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                end
                ST_WAIT_END: begin
                    if (fpu_cmd_end_i) begin
                        state_q <= ST_RD_ASSERT;
                        idx_q   <= 4'd9;
                        addr_q  <= 4'd9;
                        cs_q    <= 1'b0;
                        rd_q    <= 1'b0;
                    end
`ifdef FPU_HOST_TIMEOUT_EN
                    else if (tmo_q == '0) begin
                        state_q     <= ST_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        result_q    <= 32'h0;
                    end else begin
                        tmo_q <= tmo_q - TMO_W'(1);
                    end
`endif
                end
                ST_RD_ASSERT: begin
                    // Result bytes sit at 9..12, least significant first.
                    case (idx_q[1:0])
                        2'b01:   result_q[7:0]   <= fpu_data_in_i;
                        2'b10:   result_q[15:8]  <= fpu_data_in_i;
                        2'b11:   result_q[23:16] <= fpu_data_in_i;
                        default: result_q[31:24] <= fpu_data_in_i;
                    endcase
                    state_q <= ST_RD_RECOVER;
                    cs_q    <= 1'b1;
                    rd_q    <= 1'b1;
                end
                ST_RD_RECOVER: begin
                    if (idx_q == 4'd12) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                    end else begin
                        state_q <= ST_RD_ASSERT;
                        idx_q   <= idx_d;
                        addr_q  <= idx_d;
                        cs_q    <= 1'b0;
                        rd_q    <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (!fpu_cmd_end_i) begin
                        state_q     <= ST_RSP;
                        ack_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b0;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
